// File: rtl/ahb2apb_pkg.sv
// Shared types and constants for the multi-slave AHB-Lite to APB3 bridge.
// Optional APB ACCESS timeout is enabled by defining APB_TIMEOUT_EN.
package ahb2apb_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_WDATA  = 3'd1,
      ST_SETUP  = 3'd2,
      ST_ACCESS = 3'd3,
      ST_ERR1   = 3'd4,
      ST_ERR2   = 3'd5
   } state_t;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic HRESP_OKAY  = 1'b0;
   localparam logic HRESP_ERROR = 1'b1;

   // Slave-index field width; a single slave still needs one bit.
   function automatic int sel_width(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/ahb2apb_mslv_bridge_if.sv
// Bus bundle between the AHB interconnect, the bridge and the APB slave cluster.
// The "slave" modport is the bridge view; "master" is the surrounding system view.
interface ahb2apb_mslv_bridge_if
   import ahb2apb_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int NUM_SLV = 4
) ();

   // Handshakes: an AHB transfer is accepted only when hsel, htrans[1] and
   // hready_in are all high; hready_out low stalls the master's data phase.
   // An APB transfer completes in the first ACCESS cycle with pready[idx] high.
   logic                      hsel;
   logic [ADDR_W-1:0]         haddr;
   logic [1:0]                htrans;
   logic                      hwrite;
   logic [DATA_W-1:0]         hwdata;
   logic                      hready_in;
   logic [DATA_W-1:0]         hrdata;
   logic                      hready_out;
   logic                      hresp;
   logic [NUM_SLV-1:0]        psel;
   logic                      penable;
   logic                      pwrite;
   logic [ADDR_W-1:0]         paddr;
   logic [DATA_W-1:0]         pwdata;
   logic [NUM_SLV*DATA_W-1:0] prdata;
   logic [NUM_SLV-1:0]        pready;
   logic [NUM_SLV-1:0]        pslverr;
   state_t                    dbg_state;

   modport slave (
      input  hsel, haddr, htrans, hwrite, hwdata, hready_in,
      output hrdata, hready_out, hresp,
      output psel, penable, pwrite, paddr, pwdata,
      input  prdata, pready, pslverr,
      output dbg_state
   );

   modport master (
      output hsel, haddr, htrans, hwrite, hwdata, hready_in,
      input  hrdata, hready_out, hresp,
      input  psel, penable, pwrite, paddr, pwdata,
      output prdata, pready, pslverr,
      input  dbg_state
   );

endinterface

// File: rtl/ahb2apb_mslv_bridge_resp_mux.sv
// Selects the addressed APB slave's prdata/pready/pslverr; other slaves are ignored.
module apb_resp_mux
   import ahb2apb_pkg::*;
#(
   parameter int NUM_SLV = 4,
   parameter int DATA_W  = 32
) (
   input  logic [sel_width(NUM_SLV)-1:0] i_idx,
   input  logic [NUM_SLV*DATA_W-1:0]     i_prdata,
   input  logic [NUM_SLV-1:0]            i_pready,
   input  logic [NUM_SLV-1:0]            i_pslverr,
   output logic [DATA_W-1:0]             o_rdata,
   output logic                          o_ready,
   output logic                          o_err
);

   localparam int SEL_W = sel_width(NUM_SLV);

   always_comb begin
      o_rdata = '0;
      o_ready = 1'b0;
      o_err   = 1'b0;
      for (int i = 0; i < NUM_SLV; i++) begin
         if (i_idx == SEL_W'(i)) begin
            o_rdata = i_prdata[i*DATA_W +: DATA_W];
            o_ready = i_pready[i];
            o_err   = i_pslverr[i];
         end
      end
   end

endmodule

// File: rtl/ahb2apb_mslv_bridge.sv
// AHB-Lite slave to APB3 master bridge for NUM_SLV peripherals with one-hot psel.
// Define APB_TIMEOUT_EN to bound ACCESS wait states by TIMEOUT_CYC.
module ahb2apb_mslv_bridge
   import ahb2apb_pkg::*;
#(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int NUM_SLV     = 4,
   parameter int SEL_LSB     = 12,
   parameter int TIMEOUT_CYC = 255
) (
   input logic                 clk,
   input logic                 rstn,
   ahb2apb_mslv_bridge_if.slave bus
);

   localparam int SEL_W = sel_width(NUM_SLV);
   localparam logic [SEL_W:0] NUM_SLV_V = (SEL_W+1)'(NUM_SLV);

   state_t              r_state;
   state_t              w_next;
   logic [ADDR_W-1:0]   r_paddr;
   logic                r_pwrite;
   logic [DATA_W-1:0]   r_pwdata;
   logic [DATA_W-1:0]   r_hrdata;
   logic [SEL_W-1:0]    r_idx;

   logic [SEL_W-1:0]    w_hidx;
   logic                w_capture;
   logic                w_oor;
   logic [DATA_W-1:0]   w_sel_rdata;
   logic                w_sel_ready;
   logic                w_sel_err;
   logic                w_timeout;
   logic                w_hready;
   logic                w_hresp;
   logic                w_psel_en;
   logic                w_penable;

   assign w_hidx    = bus.haddr[SEL_LSB +: SEL_W];
   assign w_oor     = ({1'b0, w_hidx} >= NUM_SLV_V);
   assign w_capture = (r_state == ST_IDLE || r_state == ST_ERR2) && bus.hsel && bus.hready_in &&
                      (bus.htrans == HTRANS_NONSEQ || bus.htrans == HTRANS_SEQ);

   apb_resp_mux #(
      .NUM_SLV (NUM_SLV),
      .DATA_W  (DATA_W)
   ) u_resp_mux (
      .i_idx     (r_idx),
      .i_prdata  (bus.prdata),
      .i_pready  (bus.pready),
      .i_pslverr (bus.pslverr),
      .o_rdata   (w_sel_rdata),
      .o_ready   (w_sel_ready),
      .o_err     (w_sel_err)
   );

`ifdef APB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
   logic [CNT_W-1:0] r_to_cnt;

   // The last permitted wait cycle is the one where the count shows TIMEOUT_CYC-1.
   assign w_timeout = (r_to_cnt == CNT_W'(TIMEOUT_CYC - 1));

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_to_cnt <= '0;
      end else if (r_state == ST_ACCESS && !w_sel_ready && !w_timeout) begin
         r_to_cnt <= r_to_cnt + 1'b1;
      end else begin
         r_to_cnt <= '0;
      end
   end
`else
   localparam int timeout_cyc_unused = TIMEOUT_CYC;
   assign w_timeout = 1'b0;
`endif

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) r_state <= ST_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next    = r_state;
      w_hready  = 1'b1;
      w_hresp   = HRESP_OKAY;
      w_psel_en = 1'b0;
      w_penable = 1'b0;
      case (r_state)
         ST_IDLE, ST_ERR2: begin
            if (r_state == ST_ERR2) w_hresp = HRESP_ERROR;
            w_next = ST_IDLE;
            if (w_capture) begin
               if (w_oor)             w_next = ST_ERR1;
               else if (bus.hwrite)   w_next = ST_WDATA;
               else                   w_next = ST_SETUP;
            end
         end
         ST_WDATA: begin
            w_hready = 1'b0;
            w_next   = ST_SETUP;
         end
         ST_SETUP: begin
            w_hready  = 1'b0;
            w_psel_en = 1'b1;
            w_next    = ST_ACCESS;
         end
         ST_ACCESS: begin
            w_hready  = 1'b0;
            w_psel_en = 1'b1;
            w_penable = 1'b1;
            if (w_sel_ready)    w_next = w_sel_err ? ST_ERR1 : ST_IDLE;
            else if (w_timeout) w_next = ST_ERR1;
         end
         ST_ERR1: begin
            w_hready = 1'b0;
            w_hresp  = HRESP_ERROR;
            w_next   = ST_ERR2;
         end
         default: w_next = ST_IDLE;
      endcase
   end

   // Address/direction hold after a transfer until the next capture.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_paddr  <= '0;
         r_pwrite <= 1'b0;
         r_idx    <= '0;
         r_pwdata <= '0;
         r_hrdata <= '0;
      end else begin
         if (w_capture) begin
            r_paddr  <= bus.haddr;
            r_pwrite <= bus.hwrite;
            r_idx    <= w_hidx;
         end
         if (r_state == ST_WDATA) r_pwdata <= bus.hwdata;
         if (r_state == ST_ACCESS && w_sel_ready && !w_sel_err && !r_pwrite)
            r_hrdata <= w_sel_rdata;
      end
   end

   assign bus.hrdata     = r_hrdata;
   assign bus.hready_out = w_hready;
   assign bus.hresp      = w_hresp;
   assign bus.psel       = w_psel_en ? (NUM_SLV'(1) << r_idx) : '0;
   assign bus.penable    = w_penable;
   assign bus.pwrite     = r_pwrite;
   assign bus.paddr      = r_paddr;
   assign bus.pwdata     = r_pwdata;
   assign bus.dbg_state  = r_state;

endmodule

// File: tb/tb_ahb2apb_mslv_bridge.sv
// Randomised bench for ahb2apb_mslv_bridge (3 slaves so index 3 decodes out of range).
// Build with APB_TIMEOUT_EN to expect ERROR after TIMEOUT_CYC=8 wait cycles.
module tb_ahb2apb_mslv_bridge;
   import ahb2apb_pkg::*;

   localparam int AW     = 32;
   localparam int DW     = 32;
   localparam int NS     = 3;
   localparam int SL     = 12;
   localparam int SW     = 2;
   localparam int TO_CYC = 8;
`ifdef APB_TIMEOUT_EN
   localparam int TO_LIMIT = TO_CYC;
`else
   localparam int TO_LIMIT = 0;
`endif

   logic clk  = 1'b0;
   logic rstn = 1'b0;
   always #5 clk = ~clk;

   ahb2apb_mslv_bridge_if #(.ADDR_W(AW), .DATA_W(DW), .NUM_SLV(NS)) bus ();

   ahb2apb_mslv_bridge #(
      .ADDR_W(AW), .DATA_W(DW), .NUM_SLV(NS), .SEL_LSB(SL), .TIMEOUT_CYC(TO_CYC)
   ) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   int            n_checks = 0;
   int            n_fail   = 0;
   logic [DW-1:0] exp_q[$];
   logic [DW-1:0] exp_hrdata = '0;
   bit            pend_hresp = 1'b0;

   task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   task automatic drive_apb(input int sel, input bit rdy, input bit err, input logic [DW-1:0] rd);
      logic [NS*DW-1:0] pd;
      for (int i = 0; i < NS; i++) pd[i*DW +: DW] = $urandom;
      bus.pready  = NS'($urandom);
      bus.pslverr = NS'($urandom);
      if (sel >= 0) begin
         pd[sel*DW +: DW]  = rd;
         bus.pready[sel]   = rdy;
         bus.pslverr[sel]  = err;
      end
      bus.prdata = pd;
   endtask

   // Master activity while stalled must be ignored by the bridge.
   task automatic drive_ahb_noise();
      bus.hsel      = 1'($urandom_range(0, 1));
      bus.htrans    = 2'($urandom_range(0, 3));
      bus.haddr     = $urandom;
      bus.hwrite    = 1'($urandom_range(0, 1));
      bus.hready_in = 1'($urandom_range(0, 1));
      bus.hwdata    = $urandom;
   endtask

   task automatic check_busy(input string tag, input bit hready, input bit hresp,
                             input logic [NS-1:0] psel, input bit penable);
      check_eq({tag, "_hready"},  bus.hready_out, hready);
      check_eq({tag, "_hresp"},   bus.hresp,      hresp);
      check_eq({tag, "_psel"},    bus.psel,       psel);
      check_eq({tag, "_penable"}, bus.penable,    penable);
   endtask

   // Cycle where the bridge is IDLE or ERR2 and may accept a new address phase.
   task automatic check_open_cycle();
      if (exp_q.size() > 0) exp_hrdata = exp_q.pop_front();
      check_busy("open", 1'b1, pend_hresp, '0, 1'b0);
      check_eq("open_hrdata", bus.hrdata, exp_hrdata);
   endtask

   task automatic idle_cycle();
      int mode = $urandom_range(0, 2);
      next_cycle();
      drive_ahb_noise();
      case (mode)
         0:       bus.hsel = 1'b0;
         1:       begin bus.hsel = 1'b1; bus.htrans[1] = 1'b0; end
         default: begin bus.hsel = 1'b1; bus.htrans = HTRANS_NONSEQ; bus.hready_in = 1'b0; end
      endcase
      drive_apb(-1, 1'b0, 1'b0, '0);
      sample();
      check_open_cycle();
      pend_hresp = 1'b0;
   endtask

   task automatic xfer(input logic [AW-1:0] addr, input bit wr, input logic [DW-1:0] wdata,
                       input int waits, input bit slverr, input logic [DW-1:0] rdval);
      int            idx = int'(addr[SL +: SW]);
      logic [NS-1:0] exp_psel;
      bit            to_hit;
      int            n_acc;
      bit            last;
      // Address phase
      next_cycle();
      bus.hsel      = 1'b1;
      bus.htrans    = $urandom_range(0, 1) ? HTRANS_NONSEQ : HTRANS_SEQ;
      bus.haddr     = addr;
      bus.hwrite    = wr;
      bus.hready_in = 1'b1;
      bus.hwdata    = $urandom;
      drive_apb(-1, 1'b0, 1'b0, '0);
      sample();
      check_open_cycle();
      if (idx >= NS) begin
         next_cycle();
         drive_ahb_noise();
         drive_apb(-1, 1'b0, 1'b0, '0);
         sample();
         check_busy("oor_err1", 1'b0, 1'b1, '0, 1'b0);
         pend_hresp = 1'b1;
         return;
      end
      exp_psel = '0;
      exp_psel[idx] = 1'b1;
      if (wr) begin
         next_cycle();
         drive_ahb_noise();
         bus.hwdata = wdata;
         drive_apb(-1, 1'b0, 1'b0, '0);
         sample();
         check_busy("wdata", 1'b0, 1'b0, '0, 1'b0);
      end
      next_cycle();
      drive_ahb_noise();
      drive_apb(-1, 1'b0, 1'b0, '0);
      sample();
      check_busy("setup", 1'b0, 1'b0, exp_psel, 1'b0);
      check_eq("setup_paddr",  bus.paddr,  addr);
      check_eq("setup_pwrite", bus.pwrite, wr);
      if (wr) check_eq("setup_pwdata", bus.pwdata, wdata);
      to_hit = (TO_LIMIT > 0) && (waits >= TO_LIMIT);
      n_acc  = to_hit ? TO_LIMIT : waits + 1;
      for (int k = 0; k < n_acc; k++) begin
         last = (k == waits);
         next_cycle();
         drive_ahb_noise();
         drive_apb(idx, last, last ? slverr : 1'($urandom_range(0, 1)), last ? rdval : $urandom);
         sample();
         check_busy("access", 1'b0, 1'b0, exp_psel, 1'b1);
         check_eq("access_paddr", bus.paddr, addr);
         if (wr) check_eq("access_pwdata", bus.pwdata, wdata);
      end
      if (to_hit || slverr) begin
         next_cycle();
         drive_ahb_noise();
         drive_apb(-1, 1'b0, 1'b0, '0);
         sample();
         check_busy("err1", 1'b0, 1'b1, '0, 1'b0);
         pend_hresp = 1'b1;
      end else begin
         pend_hresp = 1'b0;
         if (!wr) exp_q.push_back(rdval);
      end
   endtask

   task automatic reset_mid_access();
      next_cycle();
      bus.hsel = 1'b1; bus.htrans = HTRANS_NONSEQ; bus.haddr = 32'h0000_0008;
      bus.hwrite = 1'b0; bus.hready_in = 1'b1;
      drive_apb(-1, 1'b0, 1'b0, '0);
      sample();
      check_open_cycle();
      next_cycle();
      drive_ahb_noise();
      sample();
      check_busy("rst_setup", 1'b0, 1'b0, 3'b001, 1'b0);
      next_cycle();
      drive_ahb_noise();
      drive_apb(0, 1'b0, 1'b0, '0);
      sample();
      check_busy("rst_access", 1'b0, 1'b0, 3'b001, 1'b1);
      #2 rstn = 1'b0;
      #1;
      check_busy("rst_async", 1'b1, 1'b0, '0, 1'b0);
      check_eq("rst_async_hrdata", bus.hrdata, '0);
      check_eq("rst_async_paddr",  bus.paddr,  '0);
      next_cycle();
      rstn = 1'b1;
      bus.hsel = 1'b0;
      exp_q.delete();
      exp_hrdata = '0;
      pend_hresp = 1'b0;
   endtask

   initial begin
      bus.hsel = 1'b0; bus.haddr = '0; bus.htrans = HTRANS_IDLE; bus.hwrite = 1'b0;
      bus.hwdata = '0; bus.hready_in = 1'b1;
      bus.prdata = '0; bus.pready = '0; bus.pslverr = '0;
      repeat (2) @(posedge clk);
      sample();
      check_busy("reset", 1'b1, 1'b0, '0, 1'b0);
      check_eq("reset_pwrite", bus.pwrite, 1'b0);
      check_eq("reset_paddr",  bus.paddr,  '0);
      check_eq("reset_pwdata", bus.pwdata, '0);
      check_eq("reset_hrdata", bus.hrdata, '0);
      next_cycle();
      rstn = 1'b1;

      xfer(32'h0000_1004, 1'b0, '0, 0, 1'b0, 32'hCAFE_0001);
      idle_cycle();
      xfer(32'h0000_2010, 1'b1, 32'hA5A5_5A5A, 0, 1'b0, $urandom);
      idle_cycle();
      xfer(32'h0000_2000, 1'b0, '0, 3, 1'b1, $urandom);
      idle_cycle();
      idle_cycle();
      xfer(32'h0000_3000, 1'b0, '0, 0, 1'b0, $urandom);
      idle_cycle();
      idle_cycle();
      xfer(32'h0000_0000, 1'b0, '0, 0, 1'b0, 32'h1111_0000);
      xfer(32'h0000_1000, 1'b0, '0, 0, 1'b0, 32'h2222_0001);
      xfer(32'h0000_3004, 1'b1, $urandom, 0, 1'b0, $urandom);
      xfer(32'h0000_1008, 1'b0, '0, 1, 1'b0, $urandom);
      idle_cycle();
      reset_mid_access();
      xfer(32'h0000_1000, 1'b0, '0, 10, 1'b0, $urandom);
      idle_cycle();
      idle_cycle();

      for (int t = 0; t < 250; t++) begin
         int waits = ($urandom_range(0, 19) == 0) ? $urandom_range(8, 11) : $urandom_range(0, 4);
         xfer($urandom, 1'($urandom_range(0, 1)), $urandom, waits,
              ($urandom_range(0, 5) == 0), $urandom);
         repeat ($urandom_range(0, 2)) idle_cycle();
      end
      idle_cycle();
      idle_cycle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/ahb2apb_mslv_bridge.md
Name: ahb2apb_mslv_bridge

Overview:
- Parametrised AHB-Lite slave to APB3 master bridge serving NUM_SLV APB peripherals.
- Decodes the slave index from captured address bits and drives a one-hot psel vector.
- Honours the AHB address/data phase split, so write data is taken in the data phase.
- Maps pslverr to a two-cycle AHB ERROR response; out-of-range decodes also get an ERROR response.
- Sits between the AHB interconnect and the APB peripheral cluster; supersedes the single-slave bridge.

Parameters:
- ADDR_W, 32, width of haddr/paddr.
- DATA_W, 32, width of all data buses.
- NUM_SLV, 4, number of APB slaves (1..16).
- SEL_LSB, 12, lowest haddr bit of the slave-index field; field width SEL_W = max(1, clog2(NUM_SLV)).
- TIMEOUT_CYC, 255, ACCESS wait-cycle limit (used only with APB_TIMEOUT_EN).

Ports:
- clk  in  1  clock, all logic on rising edge.
- rstn  in  1  asynchronous active-low reset.
- hsel  in  1  AHB slave select.
- haddr  in  ADDR_W  AHB address.
- htrans  in  2  AHB transfer type; only htrans[1]=1 (NONSEQ/SEQ) starts a transfer.
- hwrite  in  1  AHB direction.
- hwdata  in  DATA_W  AHB write data, valid in data phase.
- hready_in  in  1  bus-level HREADY.
- hrdata  out  DATA_W  read data.
- hready_out  out  1  slave HREADYOUT.
- hresp  out  1  0=OKAY, 1=ERROR.
- psel  out  NUM_SLV  one-hot APB select.
- penable  out  1  APB enable.
- pwrite  out  1  APB direction.
- paddr  out  ADDR_W  APB address.
- pwdata  out  DATA_W  APB write data.
- prdata  in  NUM_SLV*DATA_W  flattened read data; slave i occupies [i*DATA_W +: DATA_W].
- pready  in  NUM_SLV  per-slave ready.
- pslverr  in  NUM_SLV  per-slave error.

Behaviour:
- Reset values: hrdata=0, hready_out=1, hresp=0, psel=0, penable=0, pwrite=0, paddr=0, pwdata=0, state=IDLE, timeout count=0.
- Reset is asynchronous; asserting rstn mid-transfer drops psel/penable immediately and aborts the transfer without a response.
- States: IDLE, WDATA, SETUP, ACCESS, ERR1, ERR2.
- Capture condition: hsel & htrans[1] & hready_in, while in IDLE or ERR2.
  - On capture, register haddr, hwrite and idx = haddr[SEL_LSB +: SEL_W].
  - idx >= NUM_SLV -> ERR1. Otherwise write -> WDATA, read -> SETUP.
- WDATA: latch hwdata into pwdata; go to SETUP.
- SETUP: psel[idx]=1, penable=0, paddr/pwrite valid; go to ACCESS.
- ACCESS: psel[idx]=1, penable=1.
  - pready[idx]=0 -> stay in ACCESS.
  - pready[idx]=1 & pslverr[idx]=0 -> IDLE; on reads, latch prdata slice idx into hrdata.
  - pready[idx]=1 & pslverr[idx]=1 -> ERR1; hrdata unchanged.
- ERR1: hready_out=0, hresp=1, psel=0. ERR2: hready_out=1, hresp=1. ERR2 -> IDLE unless a new capture occurs.
- hready_out=0 in WDATA, SETUP, ACCESS and ERR1; 1 in IDLE and ERR2. hresp=1 only in ERR1/ERR2.
- paddr/pwrite/pwdata hold their values after the transfer until the next capture.
- pready/pslverr/prdata of unselected slaves are ignored.
- Latency, zero-wait slave, T0 = address phase:
  - Read: SETUP T1, ACCESS T2, hready_out=1 with hrdata valid in T3.
  - Write: WDATA T1, SETUP T2, ACCESS T3, hready_out=1 in T4.
- Back-to-back: a capture in the IDLE cycle that completes the previous transfer starts the next one with no bubble.
- Ignored inputs: hready_in=0 or htrans[1]=0 never capture. hsel during busy states is ignored (hready_out=0 stalls the master).

Optional Feature:
- Macro APB_TIMEOUT_EN.
- Defined: a counter increments each ACCESS cycle with pready[idx]=0 and clears on leaving ACCESS. On reaching TIMEOUT_CYC, psel/penable drop and the state goes to ERR1 (ERROR response).
- Undefined: no counter; ACCESS waits indefinitely; TIMEOUT_CYC is unused.

Decomposition:
- Package ahb2apb_pkg holds:
  - state enum;
  - HTRANS_IDLE/BUSY/NONSEQ/SEQ constants;
  - HRESP_OKAY/ERROR constants;
  - clog2-based SEL_W helper function.
- Sub-module apb_resp_mux: combinational selection of prdata/pready/pslverr by idx, parametrised by NUM_SLV and DATA_W.

Test Plan:
- Read slave 1 at haddr=0x0000_1004, pready=1, prdata1=0xCAFE_0001 -> psel=4'b0010 in T1; penable in T2; hrdata=0xCAFE_0001 with hready_out=1 in T3.
- Write 0xA5A5_5A5A to haddr=0x0000_3010 -> pwdata=0xA5A5_5A5A and psel=4'b1000 from T2; penable in T3; hready_out=1 in T4.
- Read slave 2 with pready low for 3 cycles then pslverr=1 -> ERR1 (hready_out=0, hresp=1), then ERR2 (1,1), then IDLE with hresp=0.
- NUM_SLV=3, haddr=0x0000_3000 -> no psel asserted; ERROR response in the next two cycles.
- Two reads back-to-back to slaves 0 and 1 -> second SETUP immediately follows the first completion; rstn pulsed during ACCESS -> psel=0 and hready_out=1 asynchronously.
- With APB_TIMEOUT_EN and TIMEOUT_CYC=8, pready held low -> ERR1 after 8 ACCESS cycles, psel dropped.
